execute_stage_mc: RTL and testbench
===================================

Name: execute_stage_mc

Overview:
Parametrised multi-cycle MIPS execute stage, the successor to the single-cycle EX stage. It covers the ALU, branch-target adder, forwarding muxes and EX/MEM pipeline register. It adds an iterative multiplier and optional divider that stall the front end while they run. It sits between the ID/EX register and the MEM stage, and its outputs are the EX/MEM register.

Parameters:
DATA_W, 32, datapath width (even, ≥8)
PC_W, 10, byte-PC width for branch adder
REG_AW, 5, register-index width

Ports:
clock  in  1  clock
reset  in  1  sync active-high reset
ip_valid  in  1  ID/EX holds a real instruction
ip_flush  in  1  squash EX (taken branch resolved downstream)
ip_alu_op  in  2  00 add, 01 sub, 10 funct-decoded, 11 or
ip_funct  in  6  R-type function field
ip_alu_src  in  1  B = immediate
ip_reg_dst  in  1  dest = rd (1) / rt (0)
ip_pc_plus_4  in  PC_W  sequential PC
ip_rs_data, ip_rt_data, ip_imm  in  DATA_W  operands / sign-extended immediate
ip_rd, ip_rt  in  REG_AW  candidate destinations
ip_mem_to_reg, ip_reg_write, ip_read_en, ip_write_en, ip_branch  in  1 each  pass-through control
ip_fwd_a, ip_fwd_b  in  2  10 = EX/MEM data, 01 = MEM/WB data, else register file
ip_fwd_mem_data, ip_fwd_wb_data  in  DATA_W  forwarding sources
op_stall  out  1  hold PC, IF/ID and ID/EX this cycle
op_alu_result, op_store_data  out  DATA_W  registered
op_add_result  out  PC_W  registered branch target
op_dest_reg  out  REG_AW  registered
op_zero, op_mem_to_reg, op_reg_write, op_read_en, op_write_en, op_branch  out  1 each  registered

Behaviour:
- Reset: FSM to IDLE, counter 0. Every output register is 0, and op_stall is 0.
- Forwarding: A = fwd mux(rs). The forwarded rt feeds both the B mux (before the immediate select) and op_store_data.
- ALU op 10 decode: 0x20/0x21 add; 0x22/0x23 sub; 0x24 and; 0x25 or; 0x2A slt; 0x18 mul (low DATA_W bits of the product); 0x1A div (quotient, macro only). Any other funct gives result 0.
- slt is a true signed compare, 1 or 0, with no overflow error. Add and sub wrap modulo 2^DATA_W.
- op_zero = (result == 0).
- op_add_result = ip_pc_plus_4 + (ip_imm << 2), truncated to PC_W.
- Bubble: all registered control outputs are 0 and all data outputs are 0.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE, single-cycle op: the EX/MEM register loads the result at the next edge, so latency is 1 and op_stall is 0.
- IDLE, ip_valid with mul or div (cycle T):
  - op_stall = 1 combinationally.
  - The forwarded operands are latched.
  - The FSM moves to MUL or DIV, and the EX/MEM register loads a bubble.
- MUL/DIV: one shift-add or restoring step per cycle, DATA_W cycles. op_stall = 1 and the EX/MEM register loads a bubble each cycle. At count DATA_W-1 the FSM moves to DONE.
- DONE: op_stall = 0. The EX/MEM register loads the product or quotient with the held control. The FSM returns to IDLE and does not restart on the still-present instruction.
- Total stall is DATA_W+1 cycles; the result is visible on the outputs DATA_W+2 cycles after T.
- ip_valid = 0 in IDLE: the EX/MEM register loads a bubble.
- ip_flush in any state has priority over everything except reset:
  - the EX/MEM register loads a bubble;
  - the FSM aborts to IDLE and the counter clears;
  - op_stall = 0 that cycle.
- Reset mid-operation: behaves exactly as power-on reset, and any partial result is discarded.

Optional Feature:
EXECUTE_DIV_EN.
- Defined: funct 0x1A performs unsigned restoring division. op_alu_result is the quotient. Divide-by-zero returns all-ones, still after the full DATA_W+1-cycle stall.
- Undefined: the DIV state and divider datapath are absent, and 0x1A decodes as an unknown funct (result 0, single cycle).

Decomposition:
- Package execute_pkg:
  - funct code constants;
  - alu_op encoding;
  - forwarding-select encoding;
  - FSM state enum;
  - bubble constant for the control bundle.
- Sub-module execute_muldiv_unit:
  - iterative engine with start, abort, busy and done handshake;
  - counter and accumulator/remainder registers;
  - divider logic under the macro.
- Top level keeps the FSM, muxes, ALU, adder and pipeline register.

Test Plan:
- add: rs = 7, rt = 5 → op_alu_result = 12 one cycle later, op_zero = 0. Then sub 5 − 5 → 0, op_zero = 1.
- slt: rs = 0x80000000, rt = 1 → 1; rs = 0x7FFFFFFF, rt = 0xFFFFFFFF → 0 (no overflow error).
- Forwarding: fwd_a = 10 (mem data 9), fwd_b = 01 (wb data 4), funct or → 13; sw forwarding on B → op_store_data = forwarded value.
- mul: 0x0001_0003 × 6 → op_stall high for 33 cycles, result 0x0006_0012 appears 34 cycles after issue, bubbles (reg_write = 0) in between.
- ip_flush asserted at MUL cycle 10 → bubble, op_stall drops the same cycle, the following add completes normally. Reset asserted mid-MUL → all outputs 0.
- With EXECUTE_DIV_EN: 100 ÷ 7 → 14, 5 ÷ 0 → 0xFFFFFFFF.
- Without EXECUTE_DIV_EN: 0x1A → 0, op_stall never asserted.

Source files
------------

// File: rtl/execute_pkg.sv
// Shared encodings for the multi-cycle execute stage: funct codes, ALU/forwarding selects,
// FSM states and the pass-through control bundle.
package execute_pkg;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_MUL  = 6'h18;
  localparam logic [5:0] F_DIV  = 6'h1A;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10, ALU_OR = 2'b11
  } alu_op_e;

  // 2'b11 is treated like FWD_REG.
  typedef enum logic [1:0] {
    FWD_REG = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
    logic read_en;
    logic write_en;
    logic branch;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;
endpackage

// File: rtl/execute_muldiv_unit.sv
// Iterative shift-add multiplier (low DATA_W product bits), plus a restoring unsigned
// divider when EXECUTE_DIV_EN is defined. One step per cycle, DATA_W steps per operation.
module execute_muldiv_unit
  import execute_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
`ifdef EXECUTE_DIV_EN
  input  logic              is_div,
`endif
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);
  localparam int CW = $clog2(DATA_W);

  logic [CW-1:0]     count;
  logic [DATA_W-1:0] acc, opa, opb;
  logic [DATA_W-1:0] acc_nxt, opa_nxt, opb_nxt;

  assign done = busy && (count == CW'(DATA_W - 1));

`ifdef EXECUTE_DIV_EN
  // Divide reuses the registers: acc = remainder, opa = dividend shifting into quotient,
  // opb = divisor. A zero divisor never underflows, so the quotient fills with ones.
  logic              div_mode;
  logic [DATA_W:0]   r_sh, diff;
  assign result = div_mode ? opa : acc;
`else
  assign result = acc;
`endif

  always_comb begin
    acc_nxt = opb[0] ? acc + opa : acc;
    opa_nxt = opa << 1;
    opb_nxt = opb >> 1;
`ifdef EXECUTE_DIV_EN
    r_sh = {acc, opa[DATA_W-1]};
    diff = r_sh - {1'b0, opb};
    if (div_mode) begin
      opb_nxt = opb;
      if (!diff[DATA_W]) begin
        acc_nxt = diff[DATA_W-1:0];
        opa_nxt = {opa[DATA_W-2:0], 1'b1};
      end else begin
        acc_nxt = r_sh[DATA_W-1:0];
        opa_nxt = {opa[DATA_W-2:0], 1'b0};
      end
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset || abort) begin
      busy  <= 1'b0;
      count <= '0;
      acc   <= '0;
      opa   <= '0;
      opb   <= '0;
`ifdef EXECUTE_DIV_EN
      div_mode <= 1'b0;
`endif
    end else if (start) begin
      busy  <= 1'b1;
      count <= '0;
      acc   <= '0;
      opa   <= a;
      opb   <= b;
`ifdef EXECUTE_DIV_EN
      div_mode <= is_div;
`endif
    end else if (busy) begin
      acc   <= acc_nxt;
      opa   <= opa_nxt;
      opb   <= opb_nxt;
      count <= count + 1'b1;
      if (done) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/execute_stage_mc.sv
// Multi-cycle MIPS EX stage: forwarding, ALU, branch adder, EX/MEM register and a
// stalling mul/div sequencer. Divide support is compiled in with EXECUTE_DIV_EN.
module execute_stage_mc
  import execute_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 10,
  parameter int REG_AW = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ip_valid,
  input  logic              ip_flush,
  input  logic [1:0]        ip_alu_op,
  input  logic [5:0]        ip_funct,
  input  logic              ip_alu_src,
  input  logic              ip_reg_dst,
  input  logic [PC_W-1:0]   ip_pc_plus_4,
  input  logic [DATA_W-1:0] ip_rs_data,
  input  logic [DATA_W-1:0] ip_rt_data,
  input  logic [DATA_W-1:0] ip_imm,
  input  logic [REG_AW-1:0] ip_rd,
  input  logic [REG_AW-1:0] ip_rt,
  input  logic              ip_mem_to_reg,
  input  logic              ip_reg_write,
  input  logic              ip_read_en,
  input  logic              ip_write_en,
  input  logic              ip_branch,
  input  logic [1:0]        ip_fwd_a,
  input  logic [1:0]        ip_fwd_b,
  input  logic [DATA_W-1:0] ip_fwd_mem_data,
  input  logic [DATA_W-1:0] ip_fwd_wb_data,
  output logic              op_stall,
  output logic [DATA_W-1:0] op_alu_result,
  output logic [DATA_W-1:0] op_store_data,
  output logic [PC_W-1:0]   op_add_result,
  output logic [REG_AW-1:0] op_dest_reg,
  output logic              op_zero,
  output logic              op_mem_to_reg,
  output logic              op_reg_write,
  output logic              op_read_en,
  output logic              op_write_en,
  output logic              op_branch
);
  state_e            state;
  logic [DATA_W-1:0] a, rt_fwd, b, alu_res, md_result;
  logic [PC_W-1:0]   add_res, add_hold, nxt_add;
  logic [REG_AW-1:0] dest, dest_hold, nxt_dest;
  logic [DATA_W-1:0] store_hold, nxt_result, nxt_store;
  ctrl_t             ctrl_in, ctrl_hold, nxt_ctrl, ctrl_q;
  logic              nxt_zero, is_mul, long_op, issue_long, busy, done;

  function automatic logic [DATA_W-1:0] fwd_mux(input logic [1:0] sel,
      input logic [DATA_W-1:0] rf, input logic [DATA_W-1:0] mem, input logic [DATA_W-1:0] wb);
    if (sel == FWD_MEM) return mem;
    if (sel == FWD_WB)  return wb;
    return rf;
  endfunction

  assign a       = fwd_mux(ip_fwd_a, ip_rs_data, ip_fwd_mem_data, ip_fwd_wb_data);
  assign rt_fwd  = fwd_mux(ip_fwd_b, ip_rt_data, ip_fwd_mem_data, ip_fwd_wb_data);
  assign b       = ip_alu_src ? ip_imm : rt_fwd;
  assign add_res = ip_pc_plus_4 + {ip_imm[PC_W-3:0], 2'b00};
  assign dest    = ip_reg_dst ? ip_rd : ip_rt;
  assign ctrl_in = {ip_mem_to_reg, ip_reg_write, ip_read_en, ip_write_en, ip_branch};

  assign is_mul = (ip_alu_op == ALU_FUNCT) && (ip_funct == F_MUL);
`ifdef EXECUTE_DIV_EN
  logic is_div;
  assign is_div  = (ip_alu_op == ALU_FUNCT) && (ip_funct == F_DIV);
  assign long_op = is_mul || is_div;
`else
  assign long_op = is_mul;
`endif
  assign issue_long = (state == S_IDLE) && ip_valid && long_op;
  assign op_stall   = !reset && !ip_flush && (issue_long || busy);

  always_comb begin
    alu_res = '0;
    case (alu_op_e'(ip_alu_op))
      ALU_ADD: alu_res = a + b;
      ALU_SUB: alu_res = a - b;
      ALU_OR:  alu_res = a | b;
      ALU_FUNCT:
        case (ip_funct)
          F_ADD, F_ADDU: alu_res = a + b;
          F_SUB, F_SUBU: alu_res = a - b;
          F_AND:         alu_res = a & b;
          F_OR:          alu_res = a | b;
          F_SLT:         alu_res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
          default:       alu_res = '0;
        endcase
    endcase
  end

  execute_muldiv_unit #(.DATA_W(DATA_W)) u_muldiv (
    .clock  (clock),
    .reset  (reset),
    .start  (issue_long && !ip_flush),
    .abort  (ip_flush),
`ifdef EXECUTE_DIV_EN
    .is_div (is_div),
`endif
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (md_result)
  );

  // Everything not explicitly loaded below is a bubble.
  always_comb begin
    nxt_result = '0;
    nxt_store  = '0;
    nxt_add    = '0;
    nxt_dest   = '0;
    nxt_ctrl   = CTRL_BUBBLE;
    nxt_zero   = 1'b0;
    if (!ip_flush) begin
      if (state == S_IDLE && ip_valid && !long_op) begin
        nxt_result = alu_res;
        nxt_store  = rt_fwd;
        nxt_add    = add_res;
        nxt_dest   = dest;
        nxt_ctrl   = ctrl_in;
        nxt_zero   = (alu_res == '0);
      end else if (state == S_DONE) begin
        nxt_result = md_result;
        nxt_store  = store_hold;
        nxt_add    = add_hold;
        nxt_dest   = dest_hold;
        nxt_ctrl   = ctrl_hold;
        nxt_zero   = (md_result == '0);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      ctrl_hold     <= CTRL_BUBBLE;
      store_hold    <= '0;
      add_hold      <= '0;
      dest_hold     <= '0;
      op_alu_result <= '0;
      op_store_data <= '0;
      op_add_result <= '0;
      op_dest_reg   <= '0;
      op_zero       <= 1'b0;
      ctrl_q        <= CTRL_BUBBLE;
    end else begin
      op_alu_result <= nxt_result;
      op_store_data <= nxt_store;
      op_add_result <= nxt_add;
      op_dest_reg   <= nxt_dest;
      op_zero       <= nxt_zero;
      ctrl_q        <= nxt_ctrl;
      if (ip_flush) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE:
            if (issue_long) begin
`ifdef EXECUTE_DIV_EN
              state <= is_div ? S_DIV : S_MUL;
`else
              state <= S_MUL;
`endif
              ctrl_hold  <= ctrl_in;
              store_hold <= rt_fwd;
              add_hold   <= add_res;
              dest_hold  <= dest;
            end
          S_MUL:  if (done) state <= S_DONE;
`ifdef EXECUTE_DIV_EN
          S_DIV:  if (done) state <= S_DONE;
`endif
          // DONE never re-issues: the instruction still in ID/EX has already executed.
          S_DONE: state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign op_mem_to_reg = ctrl_q.mem_to_reg;
  assign op_reg_write  = ctrl_q.reg_write;
  assign op_read_en    = ctrl_q.read_en;
  assign op_write_en   = ctrl_q.write_en;
  assign op_branch     = ctrl_q.branch;
endmodule

// File: tb/tb_execute_stage_mc.sv
// Randomized bench for execute_stage_mc against a cycle-level behavioural model,
// with directed literal checks for add/sub/slt/forwarding/mul/flush/reset/div.
module tb_execute_stage_mc;
  localparam int DW = 32, PW = 10, AW = 5;
`ifdef EXECUTE_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset, ip_valid, ip_flush, ip_alu_src, ip_reg_dst;
  logic [1:0]    ip_alu_op, ip_fwd_a, ip_fwd_b;
  logic [5:0]    ip_funct;
  logic [PW-1:0] ip_pc_plus_4;
  logic [DW-1:0] ip_rs_data, ip_rt_data, ip_imm, ip_fwd_mem_data, ip_fwd_wb_data;
  logic [AW-1:0] ip_rd, ip_rt;
  logic          ip_mem_to_reg, ip_reg_write, ip_read_en, ip_write_en, ip_branch;
  logic          op_stall, op_zero, op_mem_to_reg, op_reg_write, op_read_en, op_write_en, op_branch;
  logic [DW-1:0] op_alu_result, op_store_data;
  logic [PW-1:0] op_add_result;
  logic [AW-1:0] op_dest_reg;

  execute_stage_mc #(.DATA_W(DW), .PC_W(PW), .REG_AW(AW)) dut (
    .clock(clock), .reset(reset), .ip_valid(ip_valid), .ip_flush(ip_flush),
    .ip_alu_op(ip_alu_op), .ip_funct(ip_funct), .ip_alu_src(ip_alu_src), .ip_reg_dst(ip_reg_dst),
    .ip_pc_plus_4(ip_pc_plus_4), .ip_rs_data(ip_rs_data), .ip_rt_data(ip_rt_data), .ip_imm(ip_imm),
    .ip_rd(ip_rd), .ip_rt(ip_rt), .ip_mem_to_reg(ip_mem_to_reg), .ip_reg_write(ip_reg_write),
    .ip_read_en(ip_read_en), .ip_write_en(ip_write_en), .ip_branch(ip_branch),
    .ip_fwd_a(ip_fwd_a), .ip_fwd_b(ip_fwd_b), .ip_fwd_mem_data(ip_fwd_mem_data),
    .ip_fwd_wb_data(ip_fwd_wb_data), .op_stall(op_stall), .op_alu_result(op_alu_result),
    .op_store_data(op_store_data), .op_add_result(op_add_result), .op_dest_reg(op_dest_reg),
    .op_zero(op_zero), .op_mem_to_reg(op_mem_to_reg), .op_reg_write(op_reg_write),
    .op_read_en(op_read_en), .op_write_en(op_write_en), .op_branch(op_branch)
  );

  int          total = 0, bad = 0;
  int          long_cnt = 0;   // cycles since a mul/div issued, 0 = none in flight
  logic [84:0] pend;
  logic        m_stall = 1'b0, s_stall;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] fwd(input logic [1:0] sel, input logic [DW-1:0] rf);
    if (sel == 2'b10) return ip_fwd_mem_data;
    if (sel == 2'b01) return ip_fwd_wb_data;
    return rf;
  endfunction

  function automatic logic [DW-1:0] ref_alu(input logic [1:0] op, input logic [5:0] f,
                                            input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [63:0] p;
    if (op == 2'b00) return x + y;
    if (op == 2'b01) return x - y;
    if (op == 2'b11) return x | y;
    case (f)
      6'h20, 6'h21: return x + y;
      6'h22, 6'h23: return x - y;
      6'h24: return x & y;
      6'h25: return x | y;
      6'h2A: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      6'h18: begin p = 64'(x) * 64'(y); return p[31:0]; end
      6'h1A: if (DIV_ON) return (y == 0) ? 32'hFFFF_FFFF : x / y;
      default: ;
    endcase
    return 32'd0;
  endfunction

  function automatic logic [84:0] ref_out();
    logic [DW-1:0] x, rtf, y, res, t;
    x   = fwd(ip_fwd_a, ip_rs_data);
    rtf = fwd(ip_fwd_b, ip_rt_data);
    y   = ip_alu_src ? ip_imm : rtf;
    res = ref_alu(ip_alu_op, ip_funct, x, y);
    t   = {22'b0, ip_pc_plus_4} + (ip_imm << 2);
    return {res, rtf, t[PW-1:0], ip_reg_dst ? ip_rd : ip_rt, res == 0,
            ip_mem_to_reg, ip_reg_write, ip_read_en, ip_write_en, ip_branch};
  endfunction

  function automatic logic [84:0] dut_out();
    return {op_alu_result, op_store_data, op_add_result, op_dest_reg, op_zero,
            op_mem_to_reg, op_reg_write, op_read_en, op_write_en, op_branch};
  endfunction

  function automatic bit is_long();
    return ip_valid && ip_alu_op == 2'b10 && (ip_funct == 6'h18 || (DIV_ON && ip_funct == 6'h1A));
  endfunction

  // One clock: predict stall and the next EX/MEM contents, then compare both.
  task automatic tick();
    logic [84:0] exp_o;
    if (reset || ip_flush) begin
      m_stall = 0; exp_o = '0; long_cnt = 0;
    end else if (long_cnt == 0) begin
      if (is_long()) begin
        m_stall = 1; exp_o = '0; long_cnt = 1; pend = ref_out();
      end else begin
        m_stall = 0; exp_o = ip_valid ? ref_out() : '0;
      end
    end else if (long_cnt <= DW) begin
      m_stall = 1; exp_o = '0; long_cnt++;
    end else begin
      m_stall = 0; exp_o = pend; long_cnt = 0;
    end
    #1;
    s_stall = op_stall;
    chk("stall", op_stall, m_stall);
    @(posedge clock); #1;
    chk("exmem", dut_out(), exp_o);
  endtask

  task automatic clr();
    {ip_valid, ip_flush, ip_alu_src, ip_reg_dst, ip_alu_op, ip_fwd_a, ip_fwd_b, ip_funct} = '0;
    {ip_pc_plus_4, ip_rs_data, ip_rt_data, ip_imm, ip_fwd_mem_data, ip_fwd_wb_data} = '0;
    {ip_rd, ip_rt, ip_mem_to_reg, ip_reg_write, ip_read_en, ip_write_en, ip_branch} = '0;
  endtask

  task automatic set_long(input logic [5:0] f, input logic [DW-1:0] x, input logic [DW-1:0] y);
    clr(); ip_valid = 1; ip_alu_op = 2'b10; ip_funct = f; ip_rs_data = x; ip_rt_data = y;
    ip_reg_write = 1; ip_reg_dst = 1; ip_rd = 5'd9;
  endtask

  task automatic rand_instr();
    logic [5:0] tbl [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h18, 6'h1A, 6'h00};
    logic [15:0] r;
    ip_valid  = ($urandom_range(0, 9) != 0);
    ip_alu_op = 2'($urandom_range(0, 3));
    ip_funct  = ($urandom_range(0, 4) == 0) ? 6'($urandom) : tbl[$urandom_range(0, 9)];
    ip_rs_data = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 200)) : $urandom;
    ip_rt_data = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
    r = 16'($urandom);
    ip_imm = {{16{r[15]}}, r};
    ip_alu_src = 1'($urandom); ip_reg_dst = 1'($urandom);
    ip_rd = 5'($urandom); ip_rt = 5'($urandom); ip_pc_plus_4 = 10'($urandom);
    {ip_mem_to_reg, ip_reg_write, ip_read_en, ip_write_en, ip_branch} = 5'($urandom);
    ip_fwd_a = 2'($urandom); ip_fwd_b = 2'($urandom);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int ns;
    reset = 1; clr();
    tick(); tick();
    chk("reset_out", dut_out(), 85'd0);
    chk("reset_stall", s_stall, 0);
    reset = 0;

    clr(); ip_valid = 1; ip_rs_data = 7; ip_rt_data = 5; ip_reg_write = 1; ip_reg_dst = 1; ip_rd = 3;
    tick();
    chk("add_res", op_alu_result, 12); chk("add_zero", op_zero, 0); chk("add_dest", op_dest_reg, 3);
    ip_alu_op = 2'b10; ip_funct = 6'h22; ip_rs_data = 5;
    tick();
    chk("sub_res", op_alu_result, 0); chk("sub_zero", op_zero, 1);
    ip_funct = 6'h2A; ip_rs_data = 32'h8000_0000; ip_rt_data = 1;
    tick(); chk("slt_neg", op_alu_result, 1);
    ip_rs_data = 32'h7FFF_FFFF; ip_rt_data = 32'hFFFF_FFFF;
    tick(); chk("slt_ovf", op_alu_result, 0);
    ip_alu_op = 2'b11; ip_fwd_a = 2'b10; ip_fwd_mem_data = 9; ip_fwd_b = 2'b01; ip_fwd_wb_data = 4;
    ip_rs_data = 100; ip_rt_data = 200;
    tick(); chk("fwd_or", op_alu_result, 13);
    clr(); ip_valid = 1; ip_alu_src = 1; ip_imm = 8; ip_rs_data = 32'h1000; ip_rt_data = 32'h11;
    ip_fwd_b = 2'b10; ip_fwd_mem_data = 32'h55; ip_write_en = 1; ip_pc_plus_4 = 10'h104;
    tick();
    chk("sw_store", op_store_data, 32'h55); chk("sw_addr", op_alu_result, 32'h1008);
    chk("sw_we", op_write_en, 1); chk("br_target", op_add_result, 10'h124);

    set_long(6'h18, 32'h0001_0003, 6);
    ns = 0;
    for (int k = 1; k <= DW + 2; k++) begin
      tick();
      if (s_stall) ns++;
      if (k == DW + 1) chk("mul_bubble", op_reg_write, 0);
    end
    chk("mul_stalls", ns, DW + 1);
    chk("mul_res", op_alu_result, 32'h0006_0012); chk("mul_rw", op_reg_write, 1);
    clr(); tick();
    chk("after_done_idle", s_stall, 0);

    set_long(6'h18, 32'h0001_0003, 6);
    for (int k = 1; k <= 10; k++) tick();
    ip_flush = 1;
    tick();
    chk("flush_stall", s_stall, 0); chk("flush_bubble", dut_out(), 85'd0);
    clr(); ip_valid = 1; ip_rs_data = 7; ip_rt_data = 5;
    tick(); chk("post_flush_add", op_alu_result, 12);

    set_long(6'h18, 32'h0001_0003, 6);
    for (int k = 1; k <= 5; k++) tick();
    reset = 1;
    tick();
    chk("midreset_out", dut_out(), 85'd0); chk("midreset_stall", s_stall, 0);
    reset = 0; clr(); tick();

`ifdef EXECUTE_DIV_EN
    set_long(6'h1A, 100, 7);
    for (int k = 1; k <= DW + 2; k++) tick();
    chk("div_100_7", op_alu_result, 14);
    clr(); tick();
    set_long(6'h1A, 5, 0);
    ns = 0;
    for (int k = 1; k <= DW + 2; k++) begin tick(); if (s_stall) ns++; end
    chk("div_by_0", op_alu_result, 32'hFFFF_FFFF); chk("div_stalls", ns, DW + 1);
`else
    set_long(6'h1A, 100, 7);
    tick();
    chk("nodiv_stall", s_stall, 0); chk("nodiv_res", op_alu_result, 0); chk("nodiv_zero", op_zero, 1);
`endif
    clr(); tick();

    for (int c = 0; c < 3000; c++) begin
      if (!m_stall) rand_instr();
      ip_fwd_mem_data = $urandom;
      ip_fwd_wb_data  = $urandom;
      ip_flush = ($urandom_range(0, 39) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
